column_shift_loader: RTL

Parametrised serial-to-column loader for partial-product compressor benches and datapaths. Each cycle it accepts one bit per column of an N×N multiplier bit matrix and shifts it into that column's register, sized to the column height. It presents complete column frames to a downstream compressor over a valid/ready handshake. It supports framed and sliding-window modes, back-pressure, and synchronous flush.

---
 rtl/column_shift_loader_if.sv | 34 +++
 rtl/column_shift_loader.sv | 114 +++++++++++
 2 files changed

// File: rtl/column_shift_loader_if.sv
// Stream-side bundle of the column shift loader: serial beats in, column frames out.
// The slave modport is the loader; the master modport is the bench or upstream/downstream pair.
interface column_shift_loader_if #(
    parameter int N = 22
);
    localparam int C = 2 * N - 1;

    // Both directions use valid/ready: a transfer happens on a rising edge where
    // valid && ready are both high; a held valid keeps its payload stable.
    logic             in_valid;
    logic [C-1:0]     in_bits;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [C*N-1:0]   out_cols;

    modport master (
        output in_valid,
        output in_bits,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_cols
    );

    modport slave (
        input  in_valid,
        input  in_bits,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_cols
    );
endinterface

// File: rtl/column_shift_loader.sv
// Serial-to-column loader: shifts one bit per column of an NxN partial-product matrix
// each beat and hands complete column frames downstream, framed or sliding-window.
module column_shift_loader #(
    parameter int N   = 22,
    parameter int FCW = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       mode,
    column_shift_loader_if.slave       bus,
    output logic [FCW-1:0]             frames
);
    localparam int C  = 2 * N - 1;
    localparam int W  = C * N;
    localparam int CW = $clog2(N + 1);

    logic [W-1:0]   arr_q, arr_d;
    logic [W-1:0]   shifted;
    logic [W-1:0]   out_cols_q, out_cols_d;
    logic           out_valid_q, out_valid_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           amode_q, amode_d;
    logic [FCW-1:0] frames_q, frames_d;

    logic last_beat;
    logic in_ready;
    logic accept;
    logic handoff;
    logic amode_eff;

    // Each column keeps only its newest h(i) bits; slots at and above h(i) stay zero.
    for (genvar i = 0; i < C; i++) begin : g_col
        localparam int H = (i + 1 < C - i) ? (i + 1) : (C - i);
        logic [H-1:0] nxt;
        if (H == 1) begin : g_h1
            assign nxt = bus.in_bits[i];
        end else begin : g_hn
            assign nxt = {arr_q[i*N +: H-1], bus.in_bits[i]};
        end
        if (H < N) begin : g_pad
            assign shifted[i*N+H +: N-H] = '0;
        end
        assign shifted[i*N +: H] = nxt;
    end

    // A beat completes a frame when it brings cnt to N, or when a sliding window is
    // already full; framed mode never leaves cnt at N, so amode need not be consulted.
    assign last_beat = (cnt_q == CW'(N - 1)) || (cnt_q == CW'(N));
    assign in_ready  = !(last_beat && out_valid_q && !bus.out_ready);
    assign accept    = bus.in_valid && in_ready && !clear;
    assign handoff   = out_valid_q && bus.out_ready;
    assign amode_eff = (cnt_q == '0) ? mode : amode_q;

    always_comb begin
        arr_d       = arr_q;
        cnt_d       = cnt_q;
        amode_d     = amode_q;
        out_cols_d  = out_cols_q;
        out_valid_d = out_valid_q;
        frames_d    = frames_q + FCW'(handoff);

        if (handoff) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            arr_d       = '0;
            cnt_d       = '0;
            amode_d     = 1'b0;
            out_cols_d  = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            amode_d = amode_eff;
            if (last_beat) begin
                out_cols_d  = shifted;
                out_valid_d = 1'b1;
                if (amode_eff) begin
                    arr_d = shifted;
                    cnt_d = CW'(N);
                end else begin
                    arr_d = '0;
                    cnt_d = '0;
                end
            end else begin
                arr_d = shifted;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_q       <= '0;
            cnt_q       <= '0;
            amode_q     <= 1'b0;
            out_cols_q  <= '0;
            out_valid_q <= 1'b0;
            frames_q    <= '0;
        end else begin
            arr_q       <= arr_d;
            cnt_q       <= cnt_d;
            amode_q     <= amode_d;
            out_cols_q  <= out_cols_d;
            out_valid_q <= out_valid_d;
            frames_q    <= frames_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_cols  = out_cols_q;
    assign frames        = frames_q;
endmodule
